// File: rtl/input_debounce_if.sv
`default_nettype none
// ============================================================================
// Module      : input_debounce_if
// Description : Signal bundle between raw input pads / downstream logic cells
//               and the input_debounce block.
//                 din     : raw asynchronous inputs (pad side drives)
//                 dout    : debounced, clk-synchronous levels
//                 changed : 1-cycle pulse, some dout bit updated
//                 rise    : per-channel 0->1 pulse (INPUT_DEBOUNCE_EDGES_EN)
//                 fall    : per-channel 1->0 pulse (INPUT_DEBOUNCE_EDGES_EN)
//               master : environment side (drives din, observes outputs)
//               slave  : debouncer side (samples din, drives outputs)
//               Optional build macro: INPUT_DEBOUNCE_EDGES_EN adds rise/fall.
// Revision    : 1.0 - initial release
// ============================================================================
interface input_debounce_if #(
  parameter int WIDTH = 2
);

  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             changed;

`ifdef INPUT_DEBOUNCE_EDGES_EN
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  modport master (
    output din,
    input  dout,
    input  changed,
    input  rise,
    input  fall
  );

  modport slave (
    input  din,
    output dout,
    output changed,
    output rise,
    output fall
  );
`else
  modport master (
    output din,
    input  dout,
    input  changed
  );

  modport slave (
    input  din,
    output dout,
    output changed
  );
`endif

endinterface
`default_nettype wire

// File: rtl/input_debounce.sv
`default_nettype none
// ============================================================================
// Module      : input_debounce
// Description : Per-channel 2-flop synchroniser plus stability counter for
//               slow external inputs. A channel's output takes a new level
//               only after the synchronised input has disagreed with the
//               current output for STABLE_CYCLES consecutive clocks.
// Ports       : clk  - system clock (only clock)
//               rst  - synchronous, active-high reset
//               bus  - input_debounce_if.slave
//                      din (in), dout/changed (out), rise/fall (out, opt.)
// Parameters  : WIDTH         channels, 1..8
//               CNT_BITS      stability counter width
//               STABLE_CYCLES stable clocks to accept a level,
//                             1 .. 2**CNT_BITS-1
// Build macro : INPUT_DEBOUNCE_EDGES_EN - adds registered rise/fall pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module input_debounce #(
  parameter int WIDTH         = 2,
  parameter int CNT_BITS      = 16,
  parameter int STABLE_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               rst,
  input_debounce_if.slave    bus
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  if (WIDTH < 1 || WIDTH > 8) begin : g_bad_width
    $error("input_debounce: WIDTH must be in 1..8");
  end

  if (STABLE_CYCLES < 1 || STABLE_CYCLES > (2**CNT_BITS) - 1) begin : g_bad_stable
    $error("input_debounce: STABLE_CYCLES must be in 1..2**CNT_BITS-1");
  end

  // Terminal count: the cycle on which the counter reads this value while
  // still mismatched is the STABLE_CYCLES-th consecutive mismatch.
  localparam logic [CNT_BITS-1:0] c_last_cnt = CNT_BITS'(STABLE_CYCLES - 1);

  // --------------------------------------------------------------------------
  // Synchroniser
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.din;
      r_sync2 <= r_sync1;
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel stability counters
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] r_dout;
  logic [WIDTH-1:0] w_mismatch;
  logic [WIDTH-1:0] w_update;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
    logic [CNT_BITS-1:0] r_cnt;

    assign w_mismatch[gi] = r_sync2[gi] ^ r_dout[gi];
    assign w_update[gi]   = w_mismatch[gi] && (r_cnt == c_last_cnt);

    // Any agreement between sync2 and dout discards the partial count, so a
    // glitch shorter than the threshold leaves no residue. The counter also
    // clears on acceptance, hence it never wraps.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt <= '0;
      end else if (!w_mismatch[gi] || w_update[gi]) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output registers
  // --------------------------------------------------------------------------
  // An update always means dout takes the opposite level, so toggling the
  // updated bits is equivalent to loading sync2 into them.
  logic r_changed;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout    <= '0;
      r_changed <= 1'b0;
    end else begin
      r_dout    <= r_dout ^ w_update;
      r_changed <= |w_update;
    end
  end

  assign bus.dout    = r_dout;
  assign bus.changed = r_changed;

`ifdef INPUT_DEBOUNCE_EDGES_EN
  // Direction of an update is the newly accepted level, i.e. sync2 at the
  // accepting edge; the masks are disjoint so rise and fall never coincide.
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_rise <= w_update &  r_sync2;
      r_fall <= w_update & ~r_sync2;
    end
  end

  assign bus.rise = r_rise;
  assign bus.fall = r_fall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_input_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_debounce
// Description : Self-checking bench for input_debounce (WIDTH=2, CNT_BITS=4,
//               STABLE_CYCLES=4). Table vectors, directed corner sequences
//               and random stimulus against a history-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_debounce;

  localparam int c_width  = 2;
  localparam int c_stable = 4;
  localparam int c_hist   = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  input_debounce_if #(.WIDTH(c_width)) u_if ();

  input_debounce #(
    .WIDTH        (c_width),
    .CNT_BITS     (4),
    .STABLE_CYCLES(c_stable)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  int checks = 0;
  int errors = 0;

  // --------------------------------------------------------------------------
  // Reference model: per-edge history of rst/din. The level seen after the
  // synchroniser at edge e is din from edge e-2 unless either of the two
  // preceding edges was a reset. A channel accepts a new level at edge e when
  // the last STABLE_CYCLES edges all disagreed with the output and no
  // acceptance/reset happened inside that window.
  // --------------------------------------------------------------------------
  logic       h_rst [c_hist];
  logic [1:0] h_din [c_hist];
  logic [1:0] h_mis [c_hist];
  int         last_ev [c_width];
  int         ed = 0;
  logic [1:0] m_dout = '0;
  logic       m_changed = 1'b0;
  logic [1:0] m_rise = '0;
  logic [1:0] m_fall = '0;

  task automatic model_edge(input logic r, input logic [1:0] d);
    logic s2;
    logic all_mis;
    h_rst[ed] = r;
    h_din[ed] = d;
    h_mis[ed] = '0;
    m_changed = 1'b0;
    m_rise    = '0;
    m_fall    = '0;
    if (r) begin
      m_dout = '0;
      for (int i = 0; i < c_width; i++) last_ev[i] = ed;
    end else begin
      for (int i = 0; i < c_width; i++) begin
        if (ed < 2) s2 = 1'b0;
        else if (h_rst[ed-1] || h_rst[ed-2]) s2 = 1'b0;
        else s2 = h_din[ed-2][i];
        h_mis[ed][i] = (s2 != m_dout[i]);
        all_mis = 1'b1;
        if (ed - last_ev[i] < c_stable) all_mis = 1'b0;
        else begin
          for (int k = ed - c_stable + 1; k <= ed; k++)
            if (!h_mis[k][i]) all_mis = 1'b0;
        end
        if (all_mis) begin
          m_dout[i]  = s2;
          last_ev[i] = ed;
          m_changed  = 1'b1;
          if (s2) m_rise[i] = 1'b1;
          else    m_fall[i] = 1'b1;
        end
      end
    end
    ed++;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", name, ed, act, exp);
    end
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after the rise.
  task automatic step(input logic r, input logic [1:0] d);
    @(negedge clk);
    rst        = r;
    u_if.din   = d;
    @(posedge clk);
    model_edge(r, d);
    #1;
    chk("model_dout", 8'(u_if.dout), 8'(m_dout));
    chk("model_changed", 8'(u_if.changed), 8'(m_changed));
`ifdef INPUT_DEBOUNCE_EDGES_EN
    chk("model_rise", 8'(u_if.rise), 8'(m_rise));
    chk("model_fall", 8'(u_if.fall), 8'(m_fall));
`endif
  endtask

  typedef struct {
    logic       r;
    logic [1:0] d;
    logic [1:0] exp_dout;
    logic       exp_changed;
  } vec_t;

  vec_t tbl [10];
  logic [1:0] rd;

  initial begin
    u_if.din = 2'b11;
    for (int i = 0; i < c_width; i++) last_ev[i] = 0;

    // Reset held with inputs high, then release: accept after 6 edges.
    tbl[0] = '{1'b1, 2'b11, 2'b00, 1'b0};
    tbl[1] = '{1'b1, 2'b11, 2'b00, 1'b0};
    tbl[2] = '{1'b1, 2'b11, 2'b00, 1'b0};
    tbl[3] = '{1'b0, 2'b11, 2'b00, 1'b0};
    tbl[4] = '{1'b0, 2'b11, 2'b00, 1'b0};
    tbl[5] = '{1'b0, 2'b11, 2'b00, 1'b0};
    tbl[6] = '{1'b0, 2'b11, 2'b00, 1'b0};
    tbl[7] = '{1'b0, 2'b11, 2'b00, 1'b0};
    tbl[8] = '{1'b0, 2'b11, 2'b11, 1'b1};
    tbl[9] = '{1'b0, 2'b11, 2'b00, 1'b0};
    tbl[9].exp_dout = 2'b11;

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].r, tbl[i].d);
      chk("tbl_dout", 8'(u_if.dout), 8'(tbl[i].exp_dout));
      chk("tbl_changed", 8'(u_if.changed), 8'(tbl[i].exp_changed));
    end

    // Channel 0 falls 1->0: fall pulse, no rise.
    for (int i = 1; i <= 7; i++) begin
      step(1'b0, 2'b10);
      chk("fall_dout", 8'(u_if.dout), (i >= 6) ? 8'h02 : 8'h03);
      chk("fall_changed", 8'(u_if.changed), (i == 6) ? 8'h01 : 8'h00);
`ifdef INPUT_DEBOUNCE_EDGES_EN
      chk("fall_fall", 8'(u_if.fall), (i == 6) ? 8'h01 : 8'h00);
      chk("fall_rise", 8'(u_if.rise), 8'h00);
`endif
    end
    for (int i = 0; i < 8; i++) step(1'b0, 2'b00);
    chk("settle_zero", 8'(u_if.dout), 8'h00);

    // Clean step on channel 0.
    for (int i = 1; i <= 7; i++) begin
      step(1'b0, 2'b01);
      chk("step0_dout", 8'(u_if.dout), (i >= 6) ? 8'h01 : 8'h00);
      chk("step0_changed", 8'(u_if.changed), (i == 6) ? 8'h01 : 8'h00);
`ifdef INPUT_DEBOUNCE_EDGES_EN
      chk("step0_rise", 8'(u_if.rise), (i == 6) ? 8'h01 : 8'h00);
`endif
    end

    // 3-cycle glitch on channel 1 is rejected.
    for (int i = 0; i < 3; i++) step(1'b0, 2'b11);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 2'b01);
      chk("glitch_dout", 8'(u_if.dout), 8'h01);
      chk("glitch_changed", 8'(u_if.changed), 8'h00);
    end
    // 4-cycle pulse on channel 1 is accepted on the 6th edge.
    for (int i = 1; i <= 4; i++) step(1'b0, 2'b11);
    step(1'b0, 2'b01);
    step(1'b0, 2'b01);
    chk("pulse4_dout", 8'(u_if.dout), 8'h03);
    chk("pulse4_changed", 8'(u_if.changed), 8'h01);
    for (int i = 0; i < 12; i++) step(1'b0, 2'b00);
    chk("settle_zero2", 8'(u_if.dout), 8'h00);

    // Both channels step together.
    for (int i = 1; i <= 7; i++) begin
      step(1'b0, 2'b11);
      chk("both_dout", 8'(u_if.dout), (i >= 6) ? 8'h03 : 8'h00);
      chk("both_changed", 8'(u_if.changed), (i == 6) ? 8'h01 : 8'h00);
    end
    for (int i = 0; i < 10; i++) step(1'b0, 2'b00);

    // Reset two cycles into a count restarts it.
    step(1'b0, 2'b01);
    step(1'b0, 2'b01);
    step(1'b1, 2'b01);
    chk("rst_mid_dout", 8'(u_if.dout), 8'h00);
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 2'b01);
      chk("rst_mid_after", 8'(u_if.dout), (i == 6) ? 8'h01 : 8'h00);
    end

    // Random stimulus with mostly long holds, occasional resets.
    rd = 2'b01;
    for (int n = 0; n < 800; n++) begin
      for (int b = 0; b < c_width; b++)
        if ($urandom_range(0, 5) == 0) rd[b] = ~rd[b];
      step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0, rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
